ifm_window_buf: RTL

- Parametrised successor to the fixed 3-row IFM buffer: generalised kernel size K, data width, row width and stride.
- Accepts one K-pixel IFM column per handshake and maintains a KxK sliding window in a column shift register.
- Emits registered KxK windows to the PE array over a valid/ready handshake, with stride decimation, per-row refill and backpressure.
- Sits between the IFM SRAM reader and the MAC array in MITO_ACC.

---
 rtl/ifm_window_buf_if.sv | 47 ++++
 rtl/ifm_window_buf.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_window_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : ifm_window_buf_if
// Description : Bus bundle for ifm_window_buf. It carries the K-pixel IFM
//               column stream from the SRAM reader and the KxK window stream
//               to the PE array, each with a valid/ready handshake.
//               Modports:
//                 master - environment side (drives columns, accepts windows)
//                 slave  - buffer side (accepts columns, drives windows)
//               Signals:
//                 ifm_col_in    K*DW        column, row r at [r*DW +: DW]
//                 ifm_col_valid 1           column valid
//                 ifm_col_ready 1           buffer can take a column
//                 win_out       K*K*DW      window, (r,c) at [(r*K+c)*DW +: DW]
//                 win_valid     1           window pending
//                 win_ready     1           consumer takes the window
//                 win_col_idx   clog2(W+2)  padded column index of newest col
//                 row_done      1           pulse after last column of a row
// Revision    : 1.0 - initial release
// ============================================================================
interface ifm_window_buf_if #(
   parameter int DW = 8,
   parameter int K  = 3,
   parameter int W  = 32
);
   localparam int c_cw = $clog2(W + 2);

   logic [K*DW-1:0]   ifm_col_in;
   logic              ifm_col_valid;
   logic              ifm_col_ready;
   logic [K*K*DW-1:0] win_out;
   logic              win_valid;
   logic              win_ready;
   logic [c_cw-1:0]   win_col_idx;
   logic              row_done;

   modport master (
      output ifm_col_in, ifm_col_valid, win_ready,
      input  ifm_col_ready, win_out, win_valid, win_col_idx, row_done
   );

   modport slave (
      input  ifm_col_in, ifm_col_valid, win_ready,
      output ifm_col_ready, win_out, win_valid, win_col_idx, row_done
   );
endinterface
`default_nettype wire

// File: rtl/ifm_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : ifm_window_buf
// Description : KxK sliding-window buffer for the IFM path. Accepts one
//               K-pixel column per handshake into a column shift register and
//               emits registered KxK windows with horizontal stride S,
//               per-row refill and backpressure.
//               Optional feature (macro MITO_IFM_PAD_EN): one zero column of
//               same-padding is shifted in at each end of a row (PAD_L/PAD_R
//               states), making the padded row W+2 columns wide.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - ifm_window_buf_if.slave (column in, window out)
// Parameters  : DW (pixel bits), K (kernel 2..7), W (row width >= K),
//               S (stride 1..K)
// Revision    : 1.0 - initial release
// ============================================================================
module ifm_window_buf #(
   parameter int DW = 8,
   parameter int K  = 3,
   parameter int W  = 32,
   parameter int S  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   ifm_window_buf_if.slave  bus
);

`ifdef MITO_IFM_PAD_EN
   localparam int c_wp = W + 2;
`else
   localparam int c_wp = W;
`endif
   localparam int c_cw = $clog2(W + 2);
   localparam int c_sw = (S > 1) ? $clog2(S) : 1;

   localparam logic [c_cw-1:0] c_last_col   = c_cw'(c_wp - 1);
   localparam logic [c_cw-1:0] c_fill_end   = c_cw'(K - 2);
   localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
   localparam logic [c_sw-1:0] c_stride_max = c_sw'(S - 1);
   localparam logic [c_sw-1:0] c_stride_one = c_sw'(1);
`ifdef MITO_IFM_PAD_EN
   // Index of the last data column; the right pad follows it.
   localparam logic [c_cw-1:0] c_last_data  = c_cw'(W);
`endif

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1
`ifdef MITO_IFM_PAD_EN
      ,
      ST_PAD_L = 2'd2,
      ST_PAD_R = 2'd3
`endif
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [c_cw-1:0]          r_col_cnt;
   logic [c_sw-1:0]          r_stride_cnt;
   logic [K-1:0][K*DW-1:0]   r_sr;          // r_sr[0] is the oldest column
   logic [K*K*DW-1:0]        r_win_out;
   logic                     r_win_valid;
   logic [c_cw-1:0]          r_win_col_idx;
   logic                     r_row_done;

   logic                     w_adv_ok;
   logic                     w_lead_pad;
   logic                     w_ready_raw;
   logic                     w_col_ready;
   logic                     w_pad_shift;
   logic                     w_run_phase;
   logic                     w_accept;
   logic                     w_shift;
   logic                     w_last;
   logic                     w_emit;
   logic [K*DW-1:0]          w_shift_col;
   logic [K-1:0][K*DW-1:0]   w_sr_nxt;
   logic [K*K*DW-1:0]        w_win_nxt;

   // The register may advance only when no window is stuck at the output.
   assign w_adv_ok = !(r_win_valid && !bus.win_ready);

`ifdef MITO_IFM_PAD_EN
   // FILL at column 0 is the hand-off point into the left pad.
   assign w_lead_pad = (r_state == ST_FILL) && (r_col_cnt == '0);
`else
   assign w_lead_pad = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs and next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_ready_raw = 1'b0;
      w_pad_shift = 1'b0;
      w_run_phase = 1'b0;
      case (r_state)
         ST_FILL: w_ready_raw = w_adv_ok && !w_lead_pad;
         ST_RUN: begin
            w_ready_raw = w_adv_ok;
            w_run_phase = 1'b1;
         end
`ifdef MITO_IFM_PAD_EN
         ST_PAD_L: w_pad_shift = w_adv_ok;
         ST_PAD_R: begin
            w_pad_shift = w_adv_ok;
            w_run_phase = 1'b1;
         end
`endif
         default: ;
      endcase

      // Ready is held low for the whole time reset is asserted.
      w_col_ready = w_ready_raw && rst_n;
      w_accept    = bus.ifm_col_valid && w_col_ready;
      w_shift     = w_accept || w_pad_shift;
      w_last      = (r_col_cnt == c_last_col);
      w_emit      = w_shift && w_run_phase && (r_stride_cnt == '0);

      w_state_nxt = r_state;
      case (r_state)
         ST_FILL: begin
`ifdef MITO_IFM_PAD_EN
            if (w_lead_pad) begin
               w_state_nxt = ST_PAD_L;
            end else
`endif
            if (w_shift && (r_col_cnt == c_fill_end)) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_shift) begin
               if (w_last) begin
                  w_state_nxt = ST_FILL;
               end
`ifdef MITO_IFM_PAD_EN
               else if (r_col_cnt == c_last_data) begin
                  w_state_nxt = ST_PAD_R;
               end
`endif
            end
         end
`ifdef MITO_IFM_PAD_EN
         ST_PAD_L: begin
            if (w_shift) begin
               w_state_nxt = (r_col_cnt == c_fill_end) ? ST_RUN : ST_FILL;
            end
         end
         ST_PAD_R: begin
            if (w_shift) begin
               w_state_nxt = ST_FILL;
            end
         end
`endif
         default: w_state_nxt = ST_FILL;
      endcase
   end

   // ------------------------------------------------------------------------
   // Shift-register next value and window assembly from it
   // ------------------------------------------------------------------------
   assign w_shift_col = w_pad_shift ? '0 : bus.ifm_col_in;
   assign w_sr_nxt    = {w_shift_col, r_sr[K-1:1]};

   always_comb begin
      w_win_nxt = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            w_win_nxt[(r*K+c)*DW +: DW] = w_sr_nxt[c][r*DW +: DW];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_cnt     <= '0;
         r_stride_cnt  <= '0;
         r_sr          <= '0;
         r_win_out     <= '0;
         r_win_valid   <= 1'b0;
         r_win_col_idx <= '0;
         r_row_done    <= 1'b0;
      end else begin
         r_row_done <= w_shift && w_last;

         if (w_shift) begin
            r_sr      <= w_sr_nxt;
            r_col_cnt <= w_last ? '0 : (r_col_cnt + c_cnt_one);
            // Stride phase restarts at every RUN entry because all
            // non-run shifts hold it at zero.
            if (w_run_phase) begin
               r_stride_cnt <= (r_stride_cnt == c_stride_max) ? '0
                                                              : (r_stride_cnt + c_stride_one);
            end else begin
               r_stride_cnt <= '0;
            end
         end

         // An emit only happens when the output slot is free or being
         // consumed this cycle, so a load never overwrites a live window.
         if (w_emit) begin
            r_win_out     <= w_win_nxt;
            r_win_valid   <= 1'b1;
            r_win_col_idx <= r_col_cnt;
         end else if (r_win_valid && bus.win_ready) begin
            r_win_valid   <= 1'b0;
         end
      end
   end

   assign bus.ifm_col_ready = w_col_ready;
   assign bus.win_out       = r_win_out;
   assign bus.win_valid     = r_win_valid;
   assign bus.win_col_idx   = r_win_col_idx;
   assign bus.row_done      = r_row_done;

endmodule
`default_nettype wire
